// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline constants and the zigzag sequencer state type.
// Pure declarations: no logic, no latency, no flow control.
package jpeg_pkg;

  localparam int N      = 8;
  localparam int COEF_W = 5*N - 19;
  localparam int ZZ_LEN = N*N;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRAP  = 2'd1,
    DRAIN = 2'd2
  } zz_state_t;

endpackage

// File: rtl/coef_mux64.sv
// Combinational 64:1 coefficient selector over the flattened zigzag outputs.
// Zero latency; no flow control of its own.
module coef_mux64
  import jpeg_pkg::*;
#(
  parameter int W   = COEF_W,
  parameter int NUM = ZZ_LEN
) (
  input  logic [NUM*W-1:0] zz_y_i,
  input  logic [5:0]       sel_i,
  output logic [W-1:0]     dat_o
);

  assign dat_o = zz_y_i[sel_i*W +: W];

endmodule

// File: rtl/zigzag_seq.sv
// Sequences the 8x8 zigzag stage: paces column loads, strobes start (incl. wrap),
// then drains 64 coefficients. Outputs decode registered state; out_ready stalls drain.
module zigzag_seq #(
  parameter int N      = jpeg_pkg::N,
  parameter int ZZ_LEN = N*N,
  localparam int COEF_W = 5*N - 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     col_valid,
  output logic                     col_ready,
  output logic                     zz_start,
  input  logic [ZZ_LEN*COEF_W-1:0] zz_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COEF_W-1:0]        out_data,
  output logic [5:0]               out_index,
  output logic                     out_last,
  output logic                     busy
);

  localparam logic [3:0] LAST_COL = 4'(N - 1);
  localparam logic [5:0] LAST_IDX = 6'(ZZ_LEN - 1);

  jpeg_pkg::zz_state_t state_q, state_d;
  logic [3:0]          col_cnt_q, col_cnt_d;
  logic [5:0]          idx_q, idx_d;
  logic [COEF_W-1:0]   sel_dat;

  coef_mux64 #(
    .W   (COEF_W),
    .NUM (ZZ_LEN)
  ) u_mux (
    .zz_y_i (zz_y),
    .sel_i  (idx_q),
    .dat_o  (sel_dat)
  );

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    idx_d     = idx_q;
    case (state_q)
      jpeg_pkg::LOAD: begin
        if (col_valid) begin
          if (col_cnt_q == LAST_COL) begin
            state_d   = jpeg_pkg::WRAP;
            col_cnt_d = 4'd0;
          end else begin
            col_cnt_d = col_cnt_q + 4'd1;
          end
        end
      end
      // The extra start strobe here lets the zigzag count roll 8 -> 0 without a write.
      jpeg_pkg::WRAP: begin
        state_d = jpeg_pkg::DRAIN;
        idx_d   = 6'd0;
      end
      jpeg_pkg::DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = jpeg_pkg::LOAD;
            idx_d   = 6'd0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = jpeg_pkg::LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= jpeg_pkg::LOAD;
      col_cnt_q <= 4'd0;
      idx_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Reset forces every output low combinationally, not just from the next edge.
  always_comb begin
    col_ready = 1'b0;
    zz_start  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = 6'd0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      busy = (state_q != jpeg_pkg::LOAD) || (col_cnt_q != 4'd0);
      case (state_q)
        jpeg_pkg::LOAD: begin
          col_ready = 1'b1;
          zz_start  = col_valid;
        end
        jpeg_pkg::WRAP: zz_start = 1'b1;
        jpeg_pkg::DRAIN: begin
          out_valid = 1'b1;
          out_data  = sel_dat;
          out_index = idx_q;
          out_last  = (idx_q == LAST_IDX);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_seq.sv
// Randomized bench for zigzag_seq with a stand-in zigzag block and a
// transaction-level reference model of the load / wrap / drain sequence.
module tb_zigzag_seq;

  localparam int CW = 21;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            col_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            col_ready, zz_start, out_valid, out_last, busy;
  logic [CW-1:0]   out_data;
  logic [5:0]      out_index;
  logic [64*CW-1:0] zz_y;

  always #5 clk = ~clk;

  zigzag_seq dut (
    .clk       (clk),
    .reset     (reset),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .zz_start  (zz_start),
    .zz_y      (zz_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // zigzag scan tables: scan position k -> (row, col)
  int zr[64];
  int zc[64];
  // stand-in zigzag block: storage [row][col] and its column counter
  logic [CW-1:0] ymat[8][8];
  int            zcnt;
  logic [CW-1:0] xcol[8];
  // reference model
  logic [CW-1:0] mcol[8][8];
  logic [CW-1:0] exp_blk[64];
  int            m_loaded, m_k;
  bit            m_wrap;

  task automatic build_zz_y();
    for (int k = 0; k < 64; k++) zz_y[k*CW +: CW] = ymat[zr[k]][zc[k]];
  endtask

  initial begin
    int  k, cyc, phase, prev_start, nblk, bp_cnt;
    bit  bp_done, r30_done, r4_done, zs_s, rst_s;
    bit  e_cr, e_zs, e_ov, e_ol, e_busy;
    logic [CW-1:0] e_od;
    int  e_oi;
    int  head[6];
    head = '{0, 8, 1, 2, 9, 16};

    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zr[k] = r; zc[k] = s - r; k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zr[k] = r; zc[k] = s - r; k++; end
      end
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin ymat[r][c] = '0; mcol[r][c] = '0; end
    for (int i = 0; i < 8; i++) xcol[i] = '0;
    for (int i = 0; i < 64; i++) exp_blk[i] = '0;
    zcnt = 0; m_loaded = 0; m_k = -1; m_wrap = 0;
    prev_start = -1; nblk = 0; bp_cnt = 0;
    bp_done = 0; r30_done = 0; r4_done = 0;
    build_zz_y();

    for (cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk);
      phase = (cyc < 3) ? 0 : (cyc < 303) ? 1 : (cyc < 1800) ? 2 : 3;
      reset = (phase == 0);
      if (phase == 1) begin
        col_valid = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) xcol[r] = CW'(8*m_loaded + r);
      end else begin
        col_valid = (phase == 3) ? 1'b1 : ($urandom_range(0, 9) < 6);
        out_ready = ($urandom_range(0, 9) < 7);
        for (int r = 0; r < 8; r++) xcol[r] = CW'($urandom);
      end
      if (phase == 2) begin
        if (!bp_done && m_k == 10) begin bp_cnt = 5; bp_done = 1; end
        if (bp_cnt > 0) begin out_ready = 1'b0; bp_cnt--; end
        if (!r30_done && m_k == 30) begin
          reset = 1'b1; r30_done = 1;
        end else if (r30_done && !r4_done && m_k < 0 && !m_wrap && m_loaded == 4) begin
          reset = 1'b1; r4_done = 1;
        end else if ($urandom_range(0, 199) == 0) begin
          reset = 1'b1;
        end
      end
      #1;

      e_cr = 0; e_zs = 0; e_ov = 0; e_ol = 0; e_busy = 0; e_od = '0; e_oi = 0;
      if (!reset) begin
        if (m_k >= 0) begin
          e_ov = 1; e_od = exp_blk[m_k]; e_oi = m_k; e_ol = (m_k == 63); e_busy = 1;
        end else if (m_wrap) begin
          e_zs = 1; e_busy = 1;
        end else begin
          e_cr = 1; e_zs = col_valid; e_busy = (m_loaded != 0);
        end
      end
      chk("col_ready", 64'(col_ready), 64'(e_cr));
      chk("zz_start",  64'(zz_start),  64'(e_zs));
      chk("busy",      64'(busy),      64'(e_busy));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("out_last",  64'(out_last),  64'(e_ol));
      chk("out_index", 64'(out_index), 64'(e_oi));
      chk("out_data",  64'(out_data),  64'(e_od));
      if (phase == 1 && nblk == 0 && m_k >= 0 && m_k < 6)
        chk("scan_head", 64'(out_data), 64'(head[m_k]));
      if (!reset && col_valid && col_ready && !busy) begin
        if (phase == 1 && prev_start >= 0) chk("block_period", 64'(cyc - prev_start), 64'd73);
        prev_start = cyc;
      end
      if (out_valid && out_ready && out_last) nblk++;

      zs_s = zz_start;
      rst_s = reset;
      if (reset) begin
        m_loaded = 0; m_wrap = 0; m_k = -1;
      end else if (m_k >= 0) begin
        if (out_ready) m_k = (m_k == 63) ? -1 : m_k + 1;
      end else if (m_wrap) begin
        m_wrap = 0; m_k = 0;
      end else if (col_valid) begin
        for (int r = 0; r < 8; r++) mcol[m_loaded][r] = xcol[r];
        m_loaded++;
        if (m_loaded == 8) begin
          for (int i = 0; i < 64; i++) exp_blk[i] = mcol[zc[i]][zr[i]];
          m_loaded = 0; m_wrap = 1;
        end
      end

      @(posedge clk);
      #1;
      if (rst_s) zcnt = 0;
      else if (zs_s) begin
        if (zcnt < 8) for (int r = 0; r < 8; r++) ymat[r][zcnt] = xcol[r];
        zcnt = (zcnt == 8) ? 0 : zcnt + 1;
      end
      build_zz_y();
    end

    chk("blocks_min", 64'(nblk >= 10), 64'd1);
    chk("bp_seen", 64'(bp_done), 64'd1);
    chk("rst30_seen", 64'(r30_done), 64'd1);
    chk("rst4_seen", 64'(r4_done), 64'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
